// File: rtl/transpose_buffer.sv
// Square transpose store between 1-D DCT passes: lines go in as rows or columns and come back the other way.
// Define TRANSPOSE_BUF_ERR_EN to add sticky underflow/overflow flags (err_udf, err_ovf).
module transpose_buffer #(
  parameter int DW    = 16,
  parameter int MAX_N = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                wr,
  input  logic                rd,
  input  logic                direction,
  input  logic [1:0]          wr_n,
  input  logic [1:0]          rd_n,
  input  logic [DW*MAX_N-1:0] wr_data,
  output logic [DW*MAX_N-1:0] rd_data,
  output logic                rd_valid,
  output logic                rd_last,
  output logic                wr_done,
  output logic                full
`ifdef TRANSPOSE_BUF_ERR_EN
  ,
  output logic                err_udf,
  output logic                err_ovf
`endif
);
  localparam int IW = $clog2(MAX_N);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_FILL   = 2'd1,
    ST_HOLD   = 2'd2,
    ST_STREAM = 2'd3
  } state_t;

  logic [DW-1:0] cell_q  [MAX_N][MAX_N];
  logic [DW-1:0] cell_d  [MAX_N][MAX_N];
  logic [DW-1:0] wr_lane [MAX_N];
  logic [DW-1:0] rd_lane [MAX_N];

  logic [IW-1:0]       wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic [1:0]          wr_sz_q, wr_sz_d, rd_sz_q, rd_sz_d;
  state_t              state_q, state_d;
  logic [DW*MAX_N-1:0] rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_last_q, rd_last_d;
  logic                wr_done_q, wr_done_d;

  logic          wr_fire, rd_fire, wr_last, rd_last_line, blk, blk_d;
  logic [1:0]    wr_code, rd_code;
  logic [IW-1:0] wr_top, rd_top;

  function automatic logic [IW-1:0] top_line(input logic [1:0] code);
    return IW'((32'd4 << code) - 32'd1);
  endfunction

  assign wr_fire      = en & wr;
  assign rd_fire      = en & rd;
  // The first line of a block sizes itself from the live code; later lines use the latched one.
  assign wr_code      = (wr_idx_q == '0) ? wr_n : wr_sz_q;
  assign rd_code      = (rd_idx_q == '0) ? rd_n : rd_sz_q;
  assign wr_top       = top_line(wr_code);
  assign rd_top       = top_line(rd_code);
  assign wr_last      = (wr_idx_q == wr_top);
  assign rd_last_line = (rd_idx_q == rd_top);
  assign blk          = (state_q == ST_HOLD) || (state_q == ST_STREAM);

  generate
    for (genvar gi = 0; gi < MAX_N; gi++) begin : g_lane
      assign wr_lane[gi] = (IW'(gi) <= wr_top) ? wr_data[gi*DW +: DW] : '0;
      assign rd_lane[gi] = (IW'(gi) > rd_top)  ? '0 :
                           direction ? cell_q[gi][rd_idx_q] : cell_q[rd_idx_q][gi];
      assign rd_data_d[gi*DW +: DW] = rd_fire ? rd_lane[gi] : rd_data_q[gi*DW +: DW];
    end
  endgenerate

  // Reads above sample cell_q directly, so a same-cycle write never leaks into rd_data.
  always_comb begin
    cell_d = cell_q;
    if (wr_fire) begin
      for (int r = 0; r < MAX_N; r++) begin
        for (int c = 0; c < MAX_N; c++) begin
          if (direction && (IW'(r) == wr_idx_q)) begin
            cell_d[r][c] = wr_lane[c];
          end else if (!direction && (IW'(c) == wr_idx_q)) begin
            cell_d[r][c] = wr_lane[r];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < MAX_N; r++) begin
      for (int c = 0; c < MAX_N; c++) begin
        cell_q[r][c] <= cell_d[r][c];
      end
    end
  end

  always_comb begin
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    wr_sz_d    = wr_sz_q;
    rd_sz_d    = rd_sz_q;
    blk_d      = blk;
    rd_valid_d = rd_fire;
    rd_last_d  = rd_fire & rd_last_line;
    wr_done_d  = wr_fire & wr_last;
    if (wr_fire) begin
      wr_idx_d = wr_last ? '0 : wr_idx_q + IW'(1);
      if (wr_idx_q == '0) wr_sz_d = wr_n;
    end
    if (rd_fire) begin
      rd_idx_d = rd_last_line ? '0 : rd_idx_q + IW'(1);
      if (rd_idx_q == '0) rd_sz_d = rd_n;
    end
    if (wr_done_d && !rd_last_d)      blk_d = 1'b1;
    else if (rd_last_d && !wr_done_d) blk_d = 1'b0;

    if (!blk_d)       state_d = (wr_idx_d == '0) ? ST_EMPTY : ST_FILL;
    else if (rd_fire) state_d = rd_last_line ? ST_HOLD : ST_STREAM;
    else if (!blk)    state_d = ST_HOLD;
    else              state_d = state_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      wr_sz_q    <= '0;
      rd_sz_q    <= '0;
      state_q    <= ST_EMPTY;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      wr_done_q  <= 1'b0;
    end else begin
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      wr_sz_q    <= wr_sz_d;
      rd_sz_q    <= rd_sz_d;
      state_q    <= state_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      wr_done_q  <= wr_done_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_last_q;
  assign wr_done  = wr_done_q;
  assign full     = blk;

`ifdef TRANSPOSE_BUF_ERR_EN
  logic err_udf_q, err_udf_d, err_ovf_q, err_ovf_d;

  always_comb begin
    err_udf_d = err_udf_q | (rd_fire & ((state_q == ST_EMPTY) | (state_q == ST_FILL)));
    err_ovf_d = err_ovf_q | (wr_fire & ~rd_fire & (state_q == ST_HOLD));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_udf_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      err_udf_q <= err_udf_d;
      err_ovf_q <= err_ovf_d;
    end
  end

  assign err_udf = err_udf_q;
  assign err_ovf = err_ovf_q;
`endif
endmodule

// File: tb/tb_transpose_buffer.sv
// Scoreboard bench for transpose_buffer: a cell-level reference predicts every read line,
// rd_last, wr_done and full; predictions are queued at drive time and popped when the DUT responds.
module tb_transpose_buffer;
  localparam int DW = 16;
  localparam int N  = 32;
  localparam int W  = DW * N;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b0, wr = 1'b0, rd = 1'b0, direction = 1'b0;
  logic [1:0]   wr_n = 2'd0, rd_n = 2'd0;
  logic [W-1:0] wr_data = '0;
  logic [W-1:0] rd_data;
  logic         rd_valid, rd_last, wr_done, full;
`ifdef TRANSPOSE_BUF_ERR_EN
  logic         err_udf, err_ovf;
`endif

  always #5 clk = ~clk;

  transpose_buffer #(.DW(DW), .MAX_N(N)) dut (
    .clk(clk), .reset(reset), .en(en), .wr(wr), .rd(rd), .direction(direction),
    .wr_n(wr_n), .rd_n(rd_n), .wr_data(wr_data), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_last(rd_last), .wr_done(wr_done), .full(full)
`ifdef TRANSPOSE_BUF_ERR_EN
    , .err_udf(err_udf), .err_ovf(err_ovf)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference state
  logic [DW-1:0] m_cell [N][N];
  int            m_wr_idx = 0, m_rd_idx = 0;
  logic [1:0]    m_wr_sz = 2'd0, m_rd_sz = 2'd0;
  logic          m_blk = 1'b0;
  logic [W-1:0]  m_last_rd = '0;
  logic [W-1:0]  q_data [$];
  logic          q_last [$];

  function automatic logic [W-1:0] rand_line();
    logic [W-1:0] v;
    for (int j = 0; j < N; j++) v[j*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  function automatic logic [W-1:0] fill_line(input logic [DW-1:0] val);
    logic [W-1:0] v;
    for (int j = 0; j < N; j++) v[j*DW +: DW] = val;
    return v;
  endfunction

  task automatic step(input logic i_en, input logic i_wr, input logic i_rd, input logic i_dir,
                      input logic [1:0] i_wn, input logic [1:0] i_rn, input logic [W-1:0] i_data);
    logic         wf, rf, wl, rl;
    logic [1:0]   code;
    logic [W-1:0] line;
    logic [DW-1:0] v;
    int           n, k;
    en = i_en; wr = i_wr; rd = i_rd; direction = i_dir;
    wr_n = i_wn; rd_n = i_rn; wr_data = i_data;
    wf = i_en & i_wr;
    rf = i_en & i_rd;
    wl = 1'b0;
    rl = 1'b0;
    if (rf) begin
      code = (m_rd_idx == 0) ? i_rn : m_rd_sz;
      if (m_rd_idx == 0) m_rd_sz = i_rn;
      n = 4 << code;
      k = m_rd_idx;
      line = '0;
      for (int j = 0; j < n; j++) line[j*DW +: DW] = i_dir ? m_cell[j][k] : m_cell[k][j];
      rl = (k == n - 1);
      m_rd_idx = rl ? 0 : k + 1;
      q_data.push_back(line);
      q_last.push_back(rl);
    end
    if (wf) begin
      code = (m_wr_idx == 0) ? i_wn : m_wr_sz;
      if (m_wr_idx == 0) m_wr_sz = i_wn;
      n = 4 << code;
      k = m_wr_idx;
      for (int j = 0; j < N; j++) begin
        v = (j < n) ? i_data[j*DW +: DW] : '0;
        if (i_dir) m_cell[k][j] = v;
        else       m_cell[j][k] = v;
      end
      wl = (k == n - 1);
      m_wr_idx = wl ? 0 : k + 1;
    end
    if (wl && !rl)      m_blk = 1'b1;
    else if (rl && !wl) m_blk = 1'b0;

    @(posedge clk);
    #1;
    if (rf) begin
      m_last_rd = q_data.pop_front();
      rl = q_last.pop_front();
      check("rd_data", rd_data, m_last_rd);
    end else begin
      check("rd_data_hold", rd_data, m_last_rd);
    end
    check("rd_valid", W'(rd_valid), W'(rf));
    check("rd_last", W'(rd_last), W'(rl));
    check("wr_done", W'(wr_done), W'(wl));
    check("full", W'(full), W'(m_blk));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, '0);
  endtask

  task automatic do_reset();
    #1 reset = 1'b0;
    #1;
    check("rst_rd_data", rd_data, '0);
    check("rst_rd_valid", W'(rd_valid), '0);
    check("rst_rd_last", W'(rd_last), '0);
    check("rst_wr_done", W'(wr_done), '0);
    check("rst_full", W'(full), '0);
`ifdef TRANSPOSE_BUF_ERR_EN
    check("rst_err_udf", W'(err_udf), '0);
    check("rst_err_ovf", W'(err_ovf), '0);
`endif
    m_wr_idx = 0; m_rd_idx = 0; m_wr_sz = 2'd0; m_rd_sz = 2'd0;
    m_blk = 1'b0; m_last_rd = '0;
    q_data.delete(); q_last.delete();
    en = 1'b0; wr = 1'b0; rd = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [W-1:0] d;
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) m_cell[r][c] = '0;
    do_reset();
    idle();

    // 1: size 4 rows in, columns out; upper lanes carry junk that must be masked
    for (int r = 0; r < 4; r++) begin
      d = rand_line();
      for (int c = 0; c < 4; c++) d[c*DW +: DW] = DW'(r * 4 + c);
      step(1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0, d);
    end
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, '0);
      d = '0;
      for (int j = 0; j < 4; j++) d[j*DW +: DW] = DW'(4 * j + k);
      check("t1_const_line", rd_data, d);
    end
    idle();

    // 2: size 32 block A by rows, then block B by columns overlapped with reading A
    for (int r = 0; r < N; r++) step(1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 2'd3, rand_line());
    for (int r = 0; r < N; r++) step(1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 2'd3, rand_line());
    for (int r = 0; r < N; r++) step(1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 2'd3, '0);

    // 3: clear the array, write size 8, read back as size 16
    for (int r = 0; r < N; r++) step(1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 2'd3, '0);
    for (int r = 0; r < N; r++) step(1'b1, 1'b0, 1'b1, 1'b1, 2'd3, 2'd3, '0);
    for (int r = 0; r < 8; r++) step(1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 2'd1, rand_line());
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 2'd2, '0);
      if (k >= 8) check("t3_zero_line", rd_data, '0);
    end

    // 4: reset part-way through a size 8 block
    for (int r = 0; r < 3; r++) step(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 2'd1, rand_line());
    do_reset();
    for (int r = 0; r < 8; r++) step(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 2'd1, rand_line());
    for (int r = 0; r < 8; r++) step(1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 2'd1, '0);

    // 5: same-cycle read/write of one cell returns the old value
    for (int r = 0; r < 4; r++) begin
      d = rand_line();
      for (int c = 0; c < 4; c++) d[c*DW +: DW] = (r == 0 && c == 0) ? 16'h1234 : DW'(r * 4 + c + 1);
      step(1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0, d);
    end
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0, fill_line(16'hAAAA));
      if (k == 0) check("t5_old_cell", W'(rd_data[DW-1:0]), W'(16'h1234));
    end
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, '0);
      if (k == 0) check("t5_new_cell", W'(rd_data[DW-1:0]), W'(16'hAAAA));
    end
    idle();

`ifdef TRANSPOSE_BUF_ERR_EN
    // 6: sticky error flags
    do_reset();
    step(1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, '0);
    check("t6_udf_set", W'(err_udf), W'(1'b1));
    check("t6_ovf_clear", W'(err_ovf), '0);
    idle();
    check("t6_udf_sticky", W'(err_udf), W'(1'b1));
    for (int r = 0; r < 4; r++) step(1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0, rand_line());
    check("t6_ovf_before", W'(err_ovf), '0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0, rand_line());
    check("t6_ovf_set", W'(err_ovf), W'(1'b1));
    idle();
    check("t6_ovf_sticky", W'(err_ovf), W'(1'b1));
    check("t6_udf_still", W'(err_udf), W'(1'b1));
    do_reset();
    idle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
